spi_slave_phy: RTL

Bit-level SPI slave physical layer, SPI mode 0 or mode 2 (CPHA=0). It synchronises the external SCLK, CS_n and MOSI into the system clock domain and deserialises MOSI into bytes. It serialises bytes supplied by the byte-level handler onto MISO. It sits directly below spi_slave_handler and exchanges one byte per SPI byte-time through pulse/ready handshakes.

---
 rtl/spi_slave_pkg.sv | 29 ++
 rtl/spi_sync_edge.sv | 47 ++++
 rtl/spi_slave_phy.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared definitions for the SPI slave bit-level PHY (spi_slave_phy) and its
// synchroniser sub-module: FSM state encoding, byte geometry, the default idle
// fill byte, and a small tx-byte selection helper.
// -----------------------------------------------------------------------------
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int         BITS_PER_BYTE     = 8;
  localparam logic [7:0] DEFAULT_IDLE_FILL = 8'hFF;

  // Counter values at which a byte is complete / the last bit is being sampled.
  localparam logic [3:0] BYTE_DONE_CNT = 4'(BITS_PER_BYTE);
  localparam logic [3:0] LAST_BIT_CNT  = 4'(BITS_PER_BYTE - 1);

  // Byte placed into the tx shifter at a load point.
  function automatic logic [7:0] select_tx_byte(input logic       ready,
                                                input logic [7:0] data,
                                                input logic [7:0] fill);
    return ready ? data : fill;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// STAGES-flop synchroniser for an asynchronous input followed by one extra
// flop used to detect rising/falling transitions of the synchronised level.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   d_i      in   asynchronous input
//   level_o  out  synchronised level
//   rise_o   out  one-cycle pulse on a 0->1 transition of level_o
//   fall_o   out  one-cycle pulse on a 1->0 transition of level_o
//
// RESET_VAL is the level the chain assumes during reset; choosing it per signal
// controls which edge (if any) appears when reset is released.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain plus the edge-detection history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_phy.sv
// -----------------------------------------------------------------------------
// spi_slave_phy
// Bit-level SPI slave PHY, CPHA=0 (mode 0 with CPOL=0, mode 2 with CPOL=1).
// Synchronises SCLK/CS_n/MOSI into clk, deserialises MOSI into bytes (MSB
// first) and serialises handler-supplied bytes onto MISO. One byte is
// exchanged per SPI byte-time with pulse handshakes towards the handler.
//
// Parameters:
//   SYNC_STAGES  flops per input synchroniser (>= 2)
//   CPOL         SCLK idle level; sampling is always on the leading edge
//   IDLE_FILL    byte shifted out when no valid tx byte is offered
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   i_tx_byte          next byte to transmit (sampled at load points)
//   i_tx_ready         i_tx_byte valid
//   o_rx_byte          last complete received byte
//   o_byte_received    one-cycle pulse, o_rx_byte valid in the same cycle
//   o_req_next_byte    one-cycle pulse asking the handler for the next byte
//   i_spi_clk          SPI SCLK (async)
//   i_spi_cs_n         SPI chip select, active low (async)
//   i_spi_mosi         SPI MOSI (async)
//   o_spi_miso         SPI MISO
//
// Build option: define SPI_SLAVE_MISO_TRISTATE_EN to release MISO (1'bz) while
// the synchronised CS_n is high or the FSM is idle. Without it MISO drives 1
// when idle.
// -----------------------------------------------------------------------------
module spi_slave_phy
  import spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic       CPOL        = 1'b0,
  parameter logic [7:0] IDLE_FILL   = DEFAULT_IDLE_FILL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_received,
  output logic       o_req_next_byte,
  input  logic       i_spi_clk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso
);

  logic sclk_s, sclk_rise_s, sclk_fall_s;
  logic cs_n_s, cs_rise_s, cs_fall_s;
  logic lead_s, trail_s;
  logic mosi_s;
  logic unused_s;

  logic [SYNC_STAGES-1:0] mosi_sync_q;

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] tx_shift_q;
  logic [7:0] rx_shift_q;
  logic [7:0] rx_byte_q;
  logic       byte_rcvd_q;
  logic       req_q;
  logic       miso_q;

  logic [7:0] load_byte_s;
  logic [7:0] rx_next_s;

  // SCLK resets to its idle level so reset release never fakes an edge.
  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (CPOL)
  ) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (i_spi_clk),
    .level_o (sclk_s),
    .rise_o  (sclk_rise_s),
    .fall_o  (sclk_fall_s)
  );

  // CS_n resets to "selected": if reset is released while the master holds
  // CS low, no cs_fall is seen and the transfer only restarts on a genuine
  // high-to-low transition. A spurious cs_rise in IDLE is harmless.
  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_cs (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (i_spi_cs_n),
    .level_o (cs_n_s),
    .rise_o  (cs_rise_s),
    .fall_o  (cs_fall_s)
  );

  // MOSI plain synchroniser; same depth as SCLK so data aligns with the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
    end
  end

  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign lead_s  = (CPOL == 1'b0) ? sclk_rise_s : sclk_fall_s;
  assign trail_s = (CPOL == 1'b0) ? sclk_fall_s : sclk_rise_s;

  assign load_byte_s = select_tx_byte(i_tx_ready, i_tx_byte, IDLE_FILL);
  assign rx_next_s   = {rx_shift_q[6:0], mosi_s};

  // Transfer FSM: byte load, bit shifting, byte completion and handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      tx_shift_q  <= IDLE_FILL;
      rx_shift_q  <= 8'h00;
      rx_byte_q   <= 8'h00;
      byte_rcvd_q <= 1'b0;
      req_q       <= 1'b0;
      miso_q      <= 1'b1;
    end else begin
      byte_rcvd_q <= 1'b0;
      req_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          miso_q    <= 1'b1;
          bit_cnt_q <= 4'd0;
          if (cs_fall_s) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Any lead coinciding with the CS fall is deliberately ignored here.
          if (cs_rise_s) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            miso_q    <= 1'b1;
          end else begin
            tx_shift_q <= load_byte_s;
            miso_q     <= load_byte_s[7];
            bit_cnt_q  <= 4'd0;
            req_q      <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (lead_s) begin
            rx_shift_q <= rx_next_s;
            bit_cnt_q  <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT_CNT) begin
              rx_byte_q   <= rx_next_s;
              byte_rcvd_q <= 1'b1;
            end
          end else if (trail_s) begin
            if (bit_cnt_q == BYTE_DONE_CNT) begin
              // Back-to-back byte: reload without a gap.
              tx_shift_q <= load_byte_s;
              miso_q     <= load_byte_s[7];
              bit_cnt_q  <= 4'd0;
              req_q      <= 1'b1;
            end else if (bit_cnt_q != 4'd0) begin
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              miso_q     <= tx_shift_q[6];
            end
          end
          // Deselect aborts the partial byte; a byte completed on this same
          // cycle's lead has already been captured above and still reports.
          if (cs_rise_s) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            miso_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rx_byte       = rx_byte_q;
  assign o_byte_received = byte_rcvd_q;
  assign o_req_next_byte = req_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign o_spi_miso = (cs_n_s || (state_q == ST_IDLE)) ? 1'bz : miso_q;
  assign unused_s   = sclk_s;
`else
  assign o_spi_miso = miso_q;
  assign unused_s   = sclk_s ^ cs_n_s;
`endif

endmodule
